// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM states, branch-kind encoding, widths and kind priority helper
package branch_pkg;
  localparam int CNT_W = 16;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, FLUSH} state_t;
  typedef enum logic [1:0] {NONE, BEQ, BNE, BGTZ} kind_t;
  function automatic kind_t pick_kind(input logic beq, input logic bne, input logic bgtz);
    return beq ? BEQ : bne ? BNE : bgtz ? BGTZ : NONE;
  endfunction
endpackage

// File: rtl/branch_unit.sv
// branch_unit: taken decision from one-hot kind flags (beq/bne/bgtz) and compare flags (zf/msb) -> br_sel
module branch_unit (
  input  logic beq,
  input  logic bne,
  input  logic bgtz,
  input  logic zf,
  input  logic msb,
  output logic br_sel
);
  assign br_sel = (beq & zf) | (bne & ~zf) | (bgtz & ~zf & ~msb);
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch FSM; in: id_valid, beq_f/bne_f/bgtz_f, br_target, ops_ready, zf/msb; out: br_sel, pc_target, flush, stall, busy, branch_cnt/taken_cnt
module branch_ctrl
  import branch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              beq_f,
  input  logic              bne_f,
  input  logic              bgtz_f,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ops_ready,
  input  logic              zf,
  input  logic              msb,
  output logic              br_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic              stall,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  state_t state;
  kind_t kind_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0] bcnt_q, tcnt_q;
  logic det, taken;
  assign det = id_valid & (beq_f | bne_f | bgtz_f);
  branch_unit u_bu (
    .beq(kind_q == BEQ),
    .bne(kind_q == BNE),
    .bgtz(kind_q == BGTZ),
    .zf(zf),
    .msb(msb),
    .br_sel(taken)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kind_q <= NONE;
      tgt_q <= '0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (det) begin
          kind_q <= pick_kind(beq_f, bne_f, bgtz_f);
          tgt_q <= br_target;
          state <= ops_ready ? RESOLVE : WAIT_OPS;
        end
        WAIT_OPS: if (ops_ready) state <= RESOLVE;
        RESOLVE: begin
          state <= taken ? FLUSH : IDLE;
          if (~&bcnt_q) bcnt_q <= bcnt_q + CNT_W'(1);
          if (taken && ~&tcnt_q) tcnt_q <= tcnt_q + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  // outputs are forced low while rst is held so an in-flight branch never leaks a pulse
  assign busy = ~rst & (state != IDLE);
  assign stall = ~rst & ((state == IDLE & det) | state == WAIT_OPS | state == RESOLVE);
  assign br_sel = ~rst & (state == FLUSH);
  assign flush = br_sel;
  assign pc_target = br_sel ? tgt_q : '0;
  assign branch_cnt = rst ? '0 : bcnt_q;
  assign taken_cnt = rst ? '0 : tcnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven and directed self-checking bench for branch_ctrl
module tb_branch_ctrl;
  logic clk = 0;
  logic rst, id_valid, beq_f, bne_f, bgtz_f, ops_ready, zf, msb;
  logic [31:0] br_target, pc_target;
  logic br_sel, flush, stall, busy;
  logic [15:0] branch_cnt, taken_cnt;
  int total = 0, bad = 0;
  logic [15:0] exp_b, exp_t;
  typedef struct {
    logic beq, bne, bgtz, zf, msb;
    logic [31:0] tgt;
    logic taken;
  } vec_t;
  vec_t vecs[10];
  branch_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .beq_f(beq_f), .bne_f(bne_f), .bgtz_f(bgtz_f),
    .br_target(br_target), .ops_ready(ops_ready), .zf(zf), .msb(msb), .br_sel(br_sel),
    .pc_target(pc_target), .flush(flush), .stall(stall), .busy(busy),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask
  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic logic [15:0] sat(input logic [15:0] c);
    return c == 16'hFFFF ? c : c + 16'd1;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string n);
    chk32({n, " branch_cnt"}, {16'b0, branch_cnt}, {16'b0, exp_b});
    chk32({n, " taken_cnt"}, {16'b0, taken_cnt}, {16'b0, exp_t});
  endtask
  task automatic idle_ins;
    id_valid = 0; beq_f = 0; bne_f = 0; bgtz_f = 0;
    br_target = 32'hDEAD_BEEF; ops_ready = 1; zf = 0; msb = 0;
  endtask
  task automatic run_vec(input vec_t v, input string n);
    id_valid = 1; beq_f = v.beq; bne_f = v.bne; bgtz_f = v.bgtz;
    br_target = v.tgt; ops_ready = 1; zf = ~v.zf; msb = ~v.msb;
    @(negedge clk);
    chk1({n, " c0 stall"}, stall, 1);
    chk1({n, " c0 busy"}, busy, 0);
    chk1({n, " c0 br_sel"}, br_sel, 0);
    tick;
    idle_ins;
    zf = v.zf; msb = v.msb;
    @(negedge clk);
    chk1({n, " c1 stall"}, stall, 1);
    chk1({n, " c1 flush"}, flush, 0);
    chk32({n, " c1 pc"}, pc_target, 0);
    tick;
    zf = ~v.zf; msb = ~v.msb;
    exp_b = sat(exp_b);
    if (v.taken) exp_t = sat(exp_t);
    @(negedge clk);
    chk1({n, " c2 br_sel"}, br_sel, v.taken);
    chk1({n, " c2 flush"}, flush, v.taken);
    chk1({n, " c2 stall"}, stall, 0);
    chk1({n, " c2 busy"}, busy, v.taken);
    chk32({n, " c2 pc"}, pc_target, v.taken ? v.tgt : 32'h0);
    chk_cnt({n, " c2"});
    if (v.taken) begin
      tick;
      @(negedge clk);
      chk1({n, " c3 busy"}, busy, 0);
      chk1({n, " c3 br_sel"}, br_sel, 0);
    end
    tick;
  endtask
  initial begin
    vecs[0] = '{1, 0, 0, 1, 0, 32'h0000_0040, 1};
    vecs[1] = '{0, 1, 0, 1, 0, 32'h0000_0080, 0};
    vecs[2] = '{0, 0, 1, 0, 1, 32'h0000_00C0, 0};
    vecs[3] = '{0, 0, 1, 0, 0, 32'h0000_0100, 1};
    vecs[4] = '{0, 0, 1, 1, 0, 32'h0000_0140, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 32'h0000_0180, 0};
    vecs[6] = '{0, 1, 0, 0, 1, 32'h0000_01C0, 1};
    vecs[7] = '{1, 1, 0, 1, 0, 32'h0000_0200, 1};
    vecs[8] = '{0, 1, 1, 0, 1, 32'h0000_0240, 1};
    vecs[9] = '{1, 1, 1, 0, 0, 32'h1234_5678, 0};
    idle_ins;
    rst = 1;
    id_valid = 1; beq_f = 1;
    tick;
    tick;
    @(negedge clk);
    chk1("rst stall", stall, 0);
    chk1("rst busy", busy, 0);
    chk1("rst br_sel", br_sel, 0);
    chk32("rst pc", pc_target, 0);
    tick;
    rst = 0;
    idle_ins;
    exp_b = 0; exp_t = 0;
    @(negedge clk);
    chk1("idle stall", stall, 0);
    chk1("idle busy", busy, 0);
    chk_cnt("idle");
    tick;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    // operands not ready for three cycles; a second branch sits in ID meanwhile
    id_valid = 1; beq_f = 1; br_target = 32'h0000_0100; ops_ready = 0; zf = 0;
    @(negedge clk);
    chk1("wait c0 stall", stall, 1);
    chk1("wait c0 busy", busy, 0);
    tick;
    beq_f = 0; bne_f = 1; br_target = 32'h0000_0200;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk1($sformatf("wait c%0d stall", c), stall, 1);
      chk1($sformatf("wait c%0d busy", c), busy, 1);
      tick;
    end
    ops_ready = 1;
    @(negedge clk);
    chk1("wait c3 stall", stall, 1);
    tick;
    zf = 1;
    @(negedge clk);
    chk1("wait c4 stall", stall, 1);
    tick;
    bne_f = 0; bgtz_f = 1; br_target = 32'h0000_0300; zf = 0;
    exp_b = sat(exp_b); exp_t = sat(exp_t);
    @(negedge clk);
    chk1("wait c5 br_sel", br_sel, 1);
    chk1("wait c5 stall", stall, 0);
    chk32("wait c5 pc", pc_target, 32'h0000_0100);
    chk_cnt("wait c5");
    tick;
    idle_ins;
    @(negedge clk);
    chk1("wrongpath busy", busy, 0);
    chk1("wrongpath br_sel", br_sel, 0);
    tick;
    // reset lands in the RESOLVE cycle of a taken beq
    id_valid = 1; beq_f = 1; br_target = 32'h0000_0400;
    tick;
    idle_ins;
    zf = 1; rst = 1;
    @(negedge clk);
    chk1("rstres stall", stall, 0);
    tick;
    rst = 0;
    exp_b = 0; exp_t = 0;
    @(negedge clk);
    chk1("rstres br_sel", br_sel, 0);
    chk1("rstres flush", flush, 0);
    chk1("rstres busy", busy, 0);
    chk_cnt("rstres");
    tick;
    // counters preloaded near the top must stop at all-ones
    force dut.bcnt_q = 16'hFFFE;
    force dut.tcnt_q = 16'hFFFE;
    #1;
    release dut.bcnt_q;
    release dut.tcnt_q;
    exp_b = 16'hFFFE; exp_t = 16'hFFFE;
    for (int i = 0; i < 3; i++) run_vec(vecs[0], $sformatf("sat%0d", i));
    @(negedge clk);
    chk32("sat branch_cnt", {16'b0, branch_cnt}, 32'h0000_FFFF);
    chk32("sat taken_cnt", {16'b0, taken_cnt}, 32'h0000_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The clock SHALL be: clk  in  1  rising-edge clock for all state.
REQ-002 The reset SHALL be: rst  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have: id_valid  in  1  the instruction in ID is valid.
REQ-004 The block SHALL have: beq_f, bne_f, bgtz_f  in  1 each  decoded branch flags from ID.
REQ-005 The block SHALL have: br_target  in  32  branch target computed in ID.
REQ-006 The block SHALL have: ops_ready  in  1  the branch source operands are hazard-free.
REQ-007 The block SHALL have: zf, msb  in  1 each  compare zero flag and sign bit, valid in RESOLVE.
REQ-008 The block SHALL have: br_sel  out  1  PC mux selects pc_target.
REQ-009 The block SHALL have: pc_target  out  32  latched branch target.
REQ-010 The block SHALL have: flush  out  1  kill the IF/ID contents.
REQ-011 The block SHALL have: stall  out  1  hold the PC and IF/ID.
REQ-012 The block SHALL have: busy  out  1  the state is not IDLE.
REQ-013 The block SHALL have: branch_cnt, taken_cnt  out  16 each  resolved-branch and taken-branch statistics.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT_OPS, RESOLVE and FLUSH.
REQ-015 Branch detect SHALL be id_valid & (beq_f | bne_f | bgtz_f).
REQ-016 When more than one flag is set, kind priority SHALL be beq > bne > bgtz.
REQ-017 In IDLE on detect, the block SHALL latch kind and br_target and assert stall combinationally in the same cycle.
REQ-018 From IDLE on detect, the next state SHALL be RESOLVE if ops_ready=1, else WAIT_OPS.
REQ-019 With no detect, IDLE SHALL remain IDLE with all outputs 0.
REQ-020 WAIT_OPS SHALL assert stall=1 and move to RESOLVE in the cycle after ops_ready=1 is sampled.
REQ-021 RESOLVE SHALL assert stall=1 and sample zf and msb.
REQ-022 In RESOLVE, taken SHALL be (beq & zf) | (bne & ~zf) | (bgtz & ~zf & ~msb).
REQ-023 From RESOLVE, the next state SHALL be FLUSH if taken, else IDLE.
REQ-024 FLUSH SHALL last exactly one cycle with br_sel=1, flush=1, stall=0 and pc_target equal to the latched target, then go to IDLE.
REQ-025 br_sel, flush and pc_target SHALL be nonzero only in FLUSH; pc_target SHALL be 0 otherwise.
REQ-026 A branch presented in ID during FLUSH is wrong-path and SHALL be ignored.
REQ-027 A branch presented in ID during WAIT_OPS or RESOLVE SHALL NOT be latched; it stays held by the stall.
REQ-028 Best-case latency SHALL be: detect at cycle 0, RESOLVE at cycle 1, FLUSH pulse at cycle 2, IDLE at cycle 3.
REQ-029 branch_cnt SHALL increment on every exit from RESOLVE.
REQ-030 taken_cnt SHALL increment on every RESOLVE->FLUSH transition.
REQ-031 Both counters SHALL saturate at 16'hFFFF with no wrap.
REQ-032 busy SHALL equal (state != IDLE).

Reset
REQ-033 While rst=1 at a clock edge, the state SHALL become IDLE, and the latched kind, latched target and both counters SHALL clear to 0.
REQ-034 During and after reset, all outputs SHALL be 0.
REQ-035 Reset asserted in any state, including mid-FLUSH, SHALL abort the branch with no flush pulse in the following cycle.

Structure
REQ-036 The shared package branch_pkg SHALL hold the state enum, the branch-kind encoding (NONE/BEQ/BNE/BGTZ), CNT_W=16 and ADDR_W=32.
REQ-037 The taken decision SHALL be one instance of the existing branch_unit, fed by the latched kind flags, zf and msb; its br_sel output is the taken term.
REQ-038 Counters and the FSM SHALL reside in branch_ctrl; the implementation SHALL be 120-400 lines.

Verification
REQ-039 beq, ops_ready=1, br_target=32'h0000_0040, zf=1 in RESOLVE -> stall in cycles 0-1; FLUSH in cycle 2 with br_sel=1, flush=1, pc_target=32'h40; branch_cnt=1, taken_cnt=1.
REQ-040 bne with zf=1 -> no FLUSH, IDLE at cycle 2; branch_cnt=1, taken_cnt=0.
REQ-041 bgtz with (zf,msb)=(0,1) -> not taken; bgtz with (0,0) -> taken; bgtz with (1,0) -> not taken.
REQ-042 beq with ops_ready=0 for 3 cycles then 1 -> stall held 5 cycles total before FLUSH; a second branch in ID during the wait is not latched.
REQ-043 rst=1 in the RESOLVE cycle of a taken beq -> no flush pulse; next cycle IDLE, counters 0.
REQ-044 Preload both counters to 16'hFFFE, resolve 3 taken branches -> both counters read 16'hFFFF.
